// File: rtl/vga_bus_arbiter_if.sv
// Client-side request/pixel bus and arbiter-side VGA/status outputs.
// The arbiter uses the slave modport; the client cluster uses master.
interface vga_bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  done_in;
  logic [23:0] cl_x;
  logic [23:0] cl_y;
  logic [71:0] cl_rgb;
  logic [2:0]  cl_we;
  logic [2:0]  start;
  logic [2:0]  grant;
  logic [7:0]  vga_x;
  logic [7:0]  vga_y;
  logic [23:0] vga_rgb;
  logic        vga_we;
  logic        busy;
  logic        timeout_err;

  modport master (
    output req, done_in, cl_x, cl_y, cl_rgb, cl_we,
    input  start, grant, vga_x, vga_y, vga_rgb, vga_we, busy, timeout_err
  );

  modport slave (
    input  req, done_in, cl_x, cl_y, cl_rgb, cl_we,
    output start, grant, vga_x, vga_y, vga_rgb, vga_we, busy, timeout_err
  );
endinterface

// File: rtl/vga_bus_arbiter.sv
// Round-robin arbiter giving one of three drawing clients exclusive access
// to the VGA pixel port, with a per-grant hold timeout.
module vga_bus_arbiter #(
  parameter logic [16:0] TIMEOUT = 17'd70000
) (
  input logic              clk,
  input logic              reset,
  vga_bus_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 17;

  typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         start_q, start_d;
  logic [1:0]         win_q, win_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [7:0]         vx_q, vx_d;
  logic [7:0]         vy_q, vy_d;
  logic [23:0]        rgb_q, rgb_d;
  logic               we_q, we_d;

  // Search order last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] rq);
    logic [1:0] c1, c2;
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (rq[c1]) return c1;
    if (rq[c2]) return c2;
    return last;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start_d = 3'b000;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    rgb_d   = rgb_q;
    we_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          win_d   = rr_pick(last_q, bus.req);
          grant_d = 3'(3'b001 << win_d);
          start_d = grant_d;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.done_in[win_q]) begin
          grant_d = 3'b000;
          last_d  = win_q;
          state_d = RELEASE;
        end else if (cnt_q == TIMEOUT - CNT_W'(1)) begin
          grant_d = 3'b000;
          last_d  = win_q;
          terr_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = 3'b000;
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pixel path forwards only the owner's fields, one cycle late.
    if (state_q == START || state_q == RUN) begin
      we_d = bus.cl_we[win_q];
      if (bus.cl_we[win_q]) begin
        vx_d  = bus.cl_x[{win_q, 3'b000} +: 8];
        vy_d  = bus.cl_y[{win_q, 3'b000} +: 8];
        rgb_d = bus.cl_rgb[7'(win_q) * 7'd24 +: 24];
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      start_q <= 3'b000;
      win_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      vx_q    <= 8'd0;
      vy_q    <= 8'd0;
      rgb_q   <= 24'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      rgb_q   <= rgb_d;
      we_q    <= we_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.vga_x       = vx_q;
  assign bus.vga_y       = vy_q;
  assign bus.vga_rgb     = rgb_q;
  assign bus.vga_we      = we_q;
endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Transaction-level bench for vga_bus_arbiter: directed grants plus random
// requests, run lengths and pixel traffic against a behavioural model.
module tb_vga_bus_arbiter;
  localparam logic [16:0] TO = 17'd16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_bus_arbiter_if bus();
  vga_bus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  int          last_m;
  logic        terr_m, we_m, busy_m;
  logic [2:0]  grant_m, start_m;
  logic [7:0]  vx_m, vy_m;
  logic [23:0] rgb_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"},   32'(bus.grant),       32'(grant_m));
    chk({tag, ".start"},   32'(bus.start),       32'(start_m));
    chk({tag, ".busy"},    32'(bus.busy),        32'(busy_m));
    chk({tag, ".terr"},    32'(bus.timeout_err), 32'(terr_m));
    chk({tag, ".vga_we"},  32'(bus.vga_we),      32'(we_m));
    chk({tag, ".vga_x"},   32'(bus.vga_x),       32'(vx_m));
    chk({tag, ".vga_y"},   32'(bus.vga_y),       32'(vy_m));
    chk({tag, ".vga_rgb"}, 32'(bus.vga_rgb),     32'(rgb_m));
  endtask

  function automatic int pick(input int last, input logic [2:0] rq);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_m = 2; terr_m = 1'b0; we_m = 1'b0; busy_m = 1'b0;
    grant_m = 3'b000; start_m = 3'b000;
    vx_m = 8'd0; vy_m = 8'd0; rgb_m = 24'd0;
  endtask

  task automatic drive_rand(input logic [2:0] d);
    bus.done_in = d;
    bus.cl_we   = 3'($urandom);
    bus.cl_x    = 24'($urandom);
    bus.cl_y    = 24'($urandom);
    bus.cl_rgb  = 72'({$urandom, $urandom, $urandom});
  endtask

  // Expected pixel port after the coming edge, from the inputs now driven.
  task automatic vga_model(input bit active, input int w);
    if (active) begin
      we_m = bus.cl_we[w];
      if (we_m) begin
        vx_m  = bus.cl_x[8*w +: 8];
        vy_m  = bus.cl_y[8*w +: 8];
        rgb_m = bus.cl_rgb[24*w +: 24];
      end
    end else begin
      we_m = 1'b0;
    end
  endtask

  // One full ownership: entered from IDLE, returns in the next IDLE cycle.
  // len <= TO means the owner signals done in RUN cycle len.
  task automatic serve(input logic [2:0] rq, input int len, input bit fixed);
    int w;
    bit fin;
    bus.req = rq;
    drive_rand(3'($urandom));
    vga_model(1'b0, 0);
    w = pick(last_m, rq);
    step();
    grant_m = 3'(1 << w); start_m = grant_m; busy_m = 1'b1;
    check_all("start");

    bus.req = 3'($urandom);
    drive_rand(3'($urandom) & ~grant_m);
    if (fixed) begin
      bus.cl_we          = 3'b011;
      bus.cl_x[15:0]     = 16'h12A5;
      bus.cl_y[15:0]     = 16'h345A;
      bus.cl_rgb[47:0]   = 48'hFF00FF_00FF00;
    end
    vga_model(1'b1, w);
    step();
    start_m = 3'b000;
    check_all("run1");
    if (fixed) begin
      chk("fixed.vga_we",  32'(bus.vga_we),  32'd1);
      chk("fixed.vga_x",   32'(bus.vga_x),   32'h12);
      chk("fixed.vga_y",   32'(bus.vga_y),   32'h34);
      chk("fixed.vga_rgb", 32'(bus.vga_rgb), 32'hFF00FF);
    end

    fin = 1'b0;
    for (int r = 1; r <= 2 * int'(TO) && !fin; r++) begin
      logic [2:0] d;
      d = 3'($urandom) & ~grant_m;
      if (r == len) d = d | grant_m;
      bus.req = 3'($urandom);
      drive_rand(d);
      vga_model(1'b1, w);
      step();
      if (r == len || r == int'(TO)) begin
        if (r != len) terr_m = 1'b1;
        grant_m = 3'b000;
        check_all("release");
        fin = 1'b1;
      end else begin
        check_all("run");
      end
    end

    bus.req = 3'($urandom);
    drive_rand(3'($urandom));
    vga_model(1'b0, 0);
    step();
    busy_m = 1'b0;
    last_m = w;
    check_all("idle");
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000;
    drive_rand(3'b000);
    model_reset();
    step();
    step();
    check_all("reset");

    reset = 1'b0;
    bus.req = 3'b000;
    drive_rand(3'($urandom));
    step();
    check_all("idle_noreq");
    drive_rand(3'($urandom));
    step();
    check_all("idle_noreq2");

    serve(3'b111, 1, 1'b0);
    serve(3'b111, 2, 1'b1);
    serve(3'b111, 3, 1'b0);
    serve(3'b001, int'(TO), 1'b0);
    chk("done_at_limit.terr", 32'(bus.timeout_err), 32'd0);
    serve(3'b010, 20, 1'b0);
    chk("forced.terr", 32'(bus.timeout_err), 32'd1);

    for (int t = 0; t < 40; t++)
      serve(3'($urandom_range(1, 7)), int'($urandom_range(1, 20)), 1'b0);
    chk("sticky.terr", 32'(bus.timeout_err), 32'd1);

    // Abort an ownership with reset while the owner is writing pixels.
    bus.req = 3'b001;
    drive_rand(3'b000);
    step();
    chk("abort.start_grant", 32'(bus.grant), 32'(3'(1 << pick(last_m, 3'b001))));
    bus.req = 3'b000;
    drive_rand(3'b000);
    step();
    reset = 1'b1;
    drive_rand(3'b000);
    bus.cl_we = 3'b111;
    step();
    model_reset();
    check_all("abort_reset");
    bus.cl_we = 3'b111;
    step();
    check_all("abort_reset_held");

    reset = 1'b0;
    bus.req = 3'b010;
    drive_rand(3'b000);
    vga_model(1'b0, 0);
    step();
    grant_m = 3'(1 << pick(last_m, 3'b010)); start_m = grant_m; busy_m = 1'b1;
    check_all("post_reset_start");
    chk("post_reset.grant", 32'(bus.grant), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_bus_arbiter.md
VGA_BUS_ARBITER -- requirements
Module: vga_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 17'd70000, maximum RUN cycles per grant before forced release (must exceed one full 256x256 refresh).
REQ-002 Port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req  in  3  per-client draw request, level, held until grant.
REQ-005 Port: done_in  in  3  per-client completion pulse, one cycle.
REQ-006 Port: cl_x  in  24  client pixel X; client n on bits [8n+7:8n].
REQ-007 Port: cl_y  in  24  client pixel Y; same packing as cl_x.
REQ-008 Port: cl_rgb  in  72  client colour; client n on bits [24n+23:24n].
REQ-009 Port: cl_we  in  3  per-client pixel write strobe.
REQ-010 Port: start  out  3  one-cycle launch pulse to the winning client (drives its enable).
REQ-011 Port: grant  out  3  one-hot current owner; all-zero when idle.
REQ-012 Port: vga_x, vga_y  out  8 each  registered pixel address to the VGA adapter.
REQ-013 Port: vga_rgb  out  24  registered pixel colour.
REQ-014 Port: vga_we  out  1  registered pixel write enable.
REQ-015 Port: busy  out  1  high in any state other than IDLE.
REQ-016 Port: timeout_err  out  1  sticky; set on forced release, cleared only by reset.

Function
REQ-017 FSM states SHALL be IDLE, START, RUN, RELEASE; one transition per clock.
REQ-018 IDLE: if req != 0, select winner, load grant one-hot, go to START; else stay.
REQ-019 Winner SHALL be round-robin: search order last+1, last+2, last (mod 3), where last is the previous owner index.
REQ-020 START: start[winner] high for exactly this cycle, grant held, hold counter cleared to 0; next state RUN.
REQ-021 RUN: grant held; hold counter increments by 1 per cycle, saturating at TIMEOUT.
REQ-022 RUN -> RELEASE when done_in[winner]=1 or hold counter = TIMEOUT-1; done_in takes precedence (no timeout_err on that cycle).
REQ-023 A forced release (timeout without done_in) SHALL set timeout_err.
REQ-024 RELEASE: grant=0, last<=winner; next state IDLE. A one-cycle bubble between owners is mandatory.
REQ-025 done_in bits of non-granted clients SHALL be ignored in every state.
REQ-026 During START and RUN: vga_x/vga_y/vga_rgb/vga_we SHALL register the granted client's fields one cycle after they are presented (latency 1).
REQ-027 vga_we SHALL be 0 in the cycle after IDLE or RELEASE, regardless of cl_we.
REQ-028 cl_we of non-granted clients SHALL never reach vga_we.
REQ-029 vga_x/vga_y/vga_rgb SHALL hold their last value when vga_we=0.
REQ-030 Requests arriving during START/RUN/RELEASE SHALL wait; req dropped before grant is simply not served.
REQ-031 The hold counter SHALL be 17 bits, unsigned.

Reset
REQ-032 reset=1 at a clock edge SHALL force state IDLE, grant=0, start=0, vga_we=0, vga_x=0, vga_y=0, vga_rgb=0, busy=0, timeout_err=0, hold counter=0, last=2 (client 0 wins first).
REQ-033 Reset asserted mid-RUN SHALL abort the grant the next edge with no start pulse or vga_we while reset is held.

Verification
REQ-034 After reset, req=3'b111 -> cycle+1 grant=001, start=001 one cycle; done_in[0] -> RELEASE, then grant=010, then after done grant=100.
REQ-035 Client 1 granted, cl_we=3'b011, cl_x[15:8]=8'h12, cl_y[15:8]=8'h34, cl_rgb[47:24]=24'hFF00FF -> next cycle vga_we=1, vga_x=8'h12, vga_y=8'h34, vga_rgb=24'hFF00FF; client 0 data never appears.
REQ-036 Client 0 granted, no done_in for TIMEOUT cycles (test TIMEOUT=17'd16) -> RELEASE after 16 RUN cycles, timeout_err=1 and stays 1 through later grants.
REQ-037 done_in[0] and counter=TIMEOUT-1 same cycle -> RELEASE, timeout_err remains 0.
REQ-038 reset pulsed in RUN with cl_we=1 -> next cycle grant=0, vga_we=0, busy=0; after release of reset with req=3'b010 -> grant=010.
REQ-039 done_in=3'b100 while client 0 owns -> no state change; grant stays 001.
